// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage: regfile read select, load-use stall, D/X latch
// Optional stall cycle counter enabled by defining DECODE_STALL_COUNT_EN.
module decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_pc,
  input  logic [31:0] fd_ir,
  input  logic        flush,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB,
  output logic [31:0] dx_pc,
  output logic [31:0] dx_ir,
  output logic [31:0] dx_a,
  output logic [31:0] dx_b,
  output logic        dx_valid,
  output logic        stall,
  output logic [31:0] stall_count
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;
  localparam logic [4:0] REG_RSTATUS = 5'd30;

  logic [4:0] fd_op, fd_rd, fd_rs, fd_rt;
  logic [4:0] dx_op, dx_rd;
  logic       use_a, use_b;
  logic       hazard;

  assign fd_op = fd_ir[31:27];
  assign fd_rd = fd_ir[26:22];
  assign fd_rs = fd_ir[21:17];
  assign fd_rt = fd_ir[16:12];
  assign dx_op = dx_ir[31:27];
  assign dx_rd = dx_ir[26:22];

  always_comb begin
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd0;
    use_a         = 1'b0;
    use_b         = 1'b0;
    case (fd_op)
      OP_RTYPE: begin
        ctrl_readRegA = fd_rs;
        ctrl_readRegB = fd_rt;
        use_a         = 1'b1;
        use_b         = 1'b1;
      end
      // rt is still presented on port B for I-types, but never compared
      OP_ADDI, OP_LW: begin
        ctrl_readRegA = fd_rs;
        ctrl_readRegB = fd_rt;
        use_a         = 1'b1;
      end
      OP_SW, OP_BNE, OP_BLT: begin
        ctrl_readRegA = fd_rs;
        ctrl_readRegB = fd_rd;
        use_a         = 1'b1;
        use_b         = 1'b1;
      end
      OP_JR: begin
        ctrl_readRegB = fd_rd;
        use_b         = 1'b1;
      end
      OP_BEX: begin
        ctrl_readRegA = REG_RSTATUS;
        use_a         = 1'b1;
      end
      OP_J, OP_JAL, OP_SETX: begin
        ctrl_readRegA = 5'd0;
        ctrl_readRegB = 5'd0;
      end
      default: begin
        ctrl_readRegA = 5'd0;
        ctrl_readRegB = 5'd0;
      end
    endcase
  end

  // A bubble in D/X clears the hazard, so a single lw-use pair stalls one cycle.
  assign hazard = dx_valid && (dx_op == OP_LW) && (dx_rd != 5'd0) &&
                  ((use_a && (ctrl_readRegA == dx_rd)) ||
                   (use_b && (ctrl_readRegB == dx_rd)));

  assign stall = hazard && !flush;

  always_ff @(posedge clock) begin
    if (!reset) begin
      dx_pc    <= 32'd0;
      dx_ir    <= 32'd0;
      dx_a     <= 32'd0;
      dx_b     <= 32'd0;
      dx_valid <= 1'b0;
    end else if (flush || stall) begin
      dx_pc    <= fd_pc;
      dx_ir    <= 32'd0;
      dx_a     <= 32'd0;
      dx_b     <= 32'd0;
      dx_valid <= 1'b0;
    end else begin
      dx_pc    <= fd_pc;
      dx_ir    <= fd_ir;
      dx_a     <= data_readRegA;
      dx_b     <= data_readRegB;
      dx_valid <= 1'b1;
    end
  end

`ifdef DECODE_STALL_COUNT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_count <= 32'd0;
    end else if (stall && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  logic        clock;
  logic        reset;
  logic [31:0] fd_pc, fd_ir;
  logic        flush;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_readRegA, data_readRegB;
  logic [31:0] dx_pc, dx_ir, dx_a, dx_b;
  logic        dx_valid, stall;
  logic [31:0] stall_count;

  logic [31:0] rf [32];
  assign data_readRegA = rf[ctrl_readRegA];
  assign data_readRegB = rf[ctrl_readRegB];

  decode_stage dut (
    .clock(clock), .reset(reset), .fd_pc(fd_pc), .fd_ir(fd_ir), .flush(flush),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .dx_pc(dx_pc), .dx_ir(dx_ir), .dx_a(dx_a), .dx_b(dx_b),
    .dx_valid(dx_valid), .stall(stall), .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  // reference D/X contents and counter
  logic [31:0] m_pc, m_ir, m_a, m_b, m_cnt;
  bit          m_valid;
  bit          last_stall;
  logic [4:0]  obs_ra, obs_rb;
  logic        obs_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ins(input logic [4:0] op, rd, rs, rt, input logic [11:0] lo = 12'd0);
    return {op, rd, rs, rt, lo};
  endfunction

  // Which registers an instruction reads and whether each read matters.
  function automatic void ref_decode(input logic [31:0] ir, output logic [4:0] ra, rb,
                                     output bit ua, ub);
    logic [4:0] op;
    op = ir[31:27];
    ra = 5'd0; rb = 5'd0; ua = 0; ub = 0;
    if (op == 5'd0) begin
      ra = ir[21:17]; rb = ir[16:12]; ua = 1; ub = 1;
    end else if (op inside {5'd5, 5'd8}) begin
      ra = ir[21:17]; rb = ir[16:12]; ua = 1;
    end else if (op inside {5'd7, 5'd2, 5'd6}) begin
      ra = ir[21:17]; rb = ir[26:22]; ua = 1; ub = 1;
    end else if (op == 5'd4) begin
      rb = ir[26:22]; ub = 1;
    end else if (op == 5'd22) begin
      ra = 5'd30; ua = 1;
    end
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_a = 0; m_b = 0; m_valid = 0; m_cnt = 0;
  endtask

  // One clock: drive, check combinational outputs, clock, check D/X against the model.
  task automatic cycle(input logic [31:0] pc, ir, input bit fl, input bit rst);
    logic [4:0] ra, rb, lrd;
    bit ua, ub, exp_stall;
    fd_pc = pc; fd_ir = ir; flush = fl; reset = rst;
    #1;
    ref_decode(ir, ra, rb, ua, ub);
    lrd = m_ir[26:22];
    exp_stall = m_valid && (m_ir[31:27] == 5'd8) && (lrd != 0) &&
                ((ua && ra == lrd) || (ub && rb == lrd)) && !fl;
    obs_ra = ctrl_readRegA; obs_rb = ctrl_readRegB; obs_stall = stall;
    check("ctrl_readRegA", {27'd0, ctrl_readRegA}, {27'd0, ra});
    check("ctrl_readRegB", {27'd0, ctrl_readRegB}, {27'd0, rb});
    check("stall", {31'd0, stall}, {31'd0, exp_stall});
    last_stall = exp_stall;
    @(posedge clock);
    #1;
    if (!rst) begin
      model_reset();
    end else begin
`ifdef DECODE_STALL_COUNT_EN
      if (exp_stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
      m_pc = pc;
      if (fl || exp_stall) begin
        m_ir = 0; m_a = 0; m_b = 0; m_valid = 0;
      end else begin
        m_ir = ir; m_a = rf[ra]; m_b = rf[rb]; m_valid = 1;
      end
    end
    check("dx_pc", dx_pc, m_pc);
    check("dx_ir", dx_ir, m_ir);
    check("dx_a", dx_a, m_a);
    check("dx_b", dx_b, m_b);
    check("dx_valid", {31'd0, dx_valid}, {31'd0, m_valid});
    check("stall_count", stall_count, m_cnt);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    bit          fl;
    logic [4:0]  ra;
    logic [4:0]  rb;
    bit          st;
    bit          v;
  } vec_t;

  vec_t vt[20];
  logic [31:0] add_r5;
  logic [31:0] stall_one;

  initial begin
    reset = 0; flush = 0; fd_pc = 0; fd_ir = 0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 0; rf[1] = 5; rf[2] = 7;
    model_reset();
`ifdef DECODE_STALL_COUNT_EN
    stall_one = 1;
`else
    stall_one = 0;
`endif
    add_r5 = ins(5'd0, 5'd5, 5'd4, 5'd2);

    // reset held two cycles with an add presented
    cycle(32'h40, ins(5'd0, 5'd3, 5'd1, 5'd2), 0, 0);
    cycle(32'h40, ins(5'd0, 5'd3, 5'd1, 5'd2), 0, 0);
    check("reset dx_valid", {31'd0, dx_valid}, 32'd0);
    check("reset dx_ir", dx_ir, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);

    vt[0]  = '{100, ins(5'd0,  5'd3, 5'd1,  5'd2),          0, 5'd1,  5'd2,  0, 1};
    vt[1]  = '{104, ins(5'd8,  5'd4, 5'd1,  5'd0),          0, 5'd1,  5'd0,  0, 1};
    vt[2]  = '{108, add_r5,                                 0, 5'd4,  5'd2,  1, 0};
    vt[3]  = '{108, add_r5,                                 0, 5'd4,  5'd2,  0, 1};
    vt[4]  = '{112, ins(5'd8,  5'd6, 5'd3,  5'd0),          0, 5'd3,  5'd0,  0, 1};
    vt[5]  = '{116, ins(5'd7,  5'd6, 5'd2,  5'd0),          0, 5'd2,  5'd6,  1, 0};
    vt[6]  = '{116, ins(5'd7,  5'd6, 5'd2,  5'd0),          0, 5'd2,  5'd6,  0, 1};
    vt[7]  = '{120, ins(5'd8,  5'd6, 5'd3,  5'd0),          0, 5'd3,  5'd0,  0, 1};
    vt[8]  = '{124, ins(5'd5,  5'd7, 5'd9,  5'd6, 12'd1),   0, 5'd9,  5'd6,  0, 1};
    vt[9]  = '{128, ins(5'd8,  5'd4, 5'd1,  5'd0),          0, 5'd1,  5'd0,  0, 1};
    vt[10] = '{132, add_r5,                                 1, 5'd4,  5'd2,  0, 0};
    vt[11] = '{136, ins(5'd8,  5'd0, 5'd1,  5'd0),          0, 5'd1,  5'd0,  0, 1};
    vt[12] = '{140, ins(5'd0,  5'd1, 5'd0,  5'd0),          0, 5'd0,  5'd0,  0, 1};
    vt[13] = '{144, ins(5'd4,  5'd31, 5'd0, 5'd0),          0, 5'd0,  5'd31, 0, 1};
    vt[14] = '{148, ins(5'd22, 5'd0, 5'd0,  5'd0, 12'h5),   0, 5'd30, 5'd0,  0, 1};
    vt[15] = '{152, ins(5'd1,  5'd3, 5'd4,  5'd5),          0, 5'd0,  5'd0,  0, 1};
    vt[16] = '{156, ins(5'd8,  5'd30, 5'd1, 5'd0),          0, 5'd1,  5'd0,  0, 1};
    vt[17] = '{160, ins(5'd22, 5'd0, 5'd0,  5'd0),          0, 5'd30, 5'd0,  1, 0};
    vt[18] = '{160, ins(5'd22, 5'd0, 5'd0,  5'd0),          0, 5'd30, 5'd0,  0, 1};
    vt[19] = '{164, ins(5'd6,  5'd3, 5'd30, 5'd0),          0, 5'd30, 5'd3,  0, 1};

    for (int i = 0; i < 20; i++) begin
      cycle(vt[i].pc, vt[i].ir, vt[i].fl, 1);
      check($sformatf("vec%0d ra", i), {27'd0, obs_ra}, {27'd0, vt[i].ra});
      check($sformatf("vec%0d rb", i), {27'd0, obs_rb}, {27'd0, vt[i].rb});
      check($sformatf("vec%0d stall", i), {31'd0, obs_stall}, {31'd0, vt[i].st});
      check($sformatf("vec%0d dx_valid", i), {31'd0, dx_valid}, {31'd0, vt[i].v});
      check($sformatf("vec%0d dx_ir", i), dx_ir, vt[i].v ? vt[i].ir : 32'd0);
      if (i == 0) begin
        check("issue dx_a", dx_a, 32'd5);
        check("issue dx_b", dx_b, 32'd7);
        check("issue dx_pc", dx_pc, 32'd100);
      end
      if (i == 3) check("load-use stall_count", stall_count, stall_one);
    end

    // reset asserted while a load-use stall is active
    cycle(200, ins(5'd8, 5'd4, 5'd1, 5'd0), 0, 1);
    cycle(204, add_r5, 0, 0);
    check("mid-stall reset observed stall", {31'd0, obs_stall}, 32'd1);
    #1;
    check("stall after reset", {31'd0, stall}, 32'd0);
    check("stall_count after reset", stall_count, 32'd0);

    // randomized stream; fetch holds PC/F-D while stalled
    begin
      logic [4:0] ops [13];
      logic [31:0] pc, ir;
      bit fl, rst;
      ops = '{5'd0, 5'd5, 5'd8, 5'd8, 5'd8, 5'd7, 5'd2, 5'd6, 5'd4, 5'd22, 5'd1, 5'd3, 5'd21};
      pc = 32'h1000; ir = 0;
      for (int n = 0; n < 600; n++) begin
        if (!(last_stall && reset)) begin
          logic [4:0] op, rd;
          op = ($urandom_range(0, 19) == 0) ? 5'($urandom) : ops[$urandom_range(0, 12)];
          rd = ($urandom_range(0, 9) == 0) ? 5'd30 : 5'($urandom_range(0, 7));
          pc = pc + 4;
          ir = ins(op, rd, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 12'($urandom));
        end
        fl  = ($urandom_range(0, 7) == 0);
        rst = ($urandom_range(0, 49) != 0);
        cycle(pc, ir, fl, rst);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
